// File: rtl/bip_zone_gen.sv
// Proximity beeper: tracks the nearest valid of N distance channels, maps it
// through a programmable zone table with retreat hysteresis, and drives beeper/motor.
module bip_zone_gen #(
    parameter int N_CH      = 4,
    parameter int DW        = 12,
    parameter int NZ        = 8,
    parameter int CW        = 26,
    parameter int HYST      = 5,
    parameter int STALE_CYC = 50000000,
    localparam int ZW       = $clog2(NZ),
    localparam int NCW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*DW-1:0]   dst,
    input  logic [N_CH-1:0]      dst_valid,
    input  logic                 mute,
    input  logic                 cfg_we,
    input  logic [ZW-1:0]        cfg_addr,
    input  logic [DW-1:0]        cfg_thr,
    input  logic [CW-1:0]        cfg_period,
    output logic                 bip_en,
    output logic                 motor_en,
    output logic [ZW:0]          zone,
    output logic [NCW-1:0]       near_ch
);

    localparam int SCW = $clog2(STALE_CYC + 1);
    localparam logic [SCW-1:0] STALE_MAX = SCW'(STALE_CYC - 1);

    typedef enum logic [1:0] {SILENT, CONT, LOW, HIGH} state_t;

    logic [DW-1:0]  ch_dst [N_CH];
    logic [N_CH-1:0] ch_valid;
    logic [SCW-1:0] stale_cnt [N_CH];

    logic [DW-1:0]  min_dst;
    logic           no_tgt;
    logic [DW-1:0]  min_c;
    logic [NCW-1:0] near_c;
    logic           any_c;

    logic [DW-1:0]  thr [NZ];
    logic [CW-1:0]  per [NZ];

    logic           cand_sil;
    logic [ZW-1:0]  cand_idx;
    logic           zone_sil;
    logic [ZW-1:0]  zone_idx;
    logic [DW:0]    retreat_lim;
    logic           cand_nearer;
    logic           cand_farther;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  per_cur;
    logic [CW-1:0]  per_new;
    logic           bip;

    // Channel stage: latch samples, age them, drop channels that go quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_valid <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                ch_dst[i]    <= '0;
                stale_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (dst_valid[i]) begin
                    ch_dst[i]    <= dst[i*DW +: DW];
                    ch_valid[i]  <= 1'b1;
                    stale_cnt[i] <= '0;
                end else if (stale_cnt[i] != STALE_MAX) begin
                    stale_cnt[i] <= stale_cnt[i] + SCW'(1);
                    if (stale_cnt[i] + SCW'(1) == STALE_MAX)
                        ch_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        min_c  = '1;
        near_c = '0;
        any_c  = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_valid[i] && (!any_c || ch_dst[i] < min_c)) begin
                min_c  = ch_dst[i];
                near_c = NCW'(i);
                any_c  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_dst <= '0;
            no_tgt  <= 1'b1;
            near_ch <= '0;
        end else begin
            no_tgt <= !any_c;
            if (any_c) begin
                min_dst <= min_c;
                near_ch <= near_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NZ; k++) begin
                thr[k] <= '0;
                per[k] <= '0;
            end
        end else if (cfg_we) begin
            thr[cfg_addr] <= cfg_thr;
            per[cfg_addr] <= cfg_period;
        end
    end

    // Entry 0 is the stop zone and is keyed on its threshold, not its period.
    always_comb begin
        cand_sil = 1'b1;
        cand_idx = '0;
        for (int unsigned k = 0; k < NZ; k++) begin
            if (cand_sil && ((k == 0) ? (thr[k] != '0) : (per[k] != '0))
                && min_dst <= thr[k]) begin
                cand_sil = 1'b0;
                cand_idx = ZW'(k);
            end
        end
    end

    assign retreat_lim  = {1'b0, thr[zone_idx]} + (DW+1)'(HYST);
    assign cand_nearer  = !cand_sil && (zone_sil || cand_idx < zone_idx);
    assign cand_farther = !zone_sil && (cand_sil || cand_idx > zone_idx);

    always_ff @(posedge clk) begin
        if (rst || no_tgt) begin
            zone_sil <= 1'b1;
            zone_idx <= '0;
        end else if (cand_nearer || (cand_farther && {1'b0, min_dst} > retreat_lim)) begin
            zone_sil <= cand_sil;
            zone_idx <= cand_idx;
        end
    end

    assign per_new = per[zone_idx];

    // Counter runs 0..P-1: LOW for the first P/2 counts, HIGH for the rest.
    // A new period is only picked up when a full period completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SILENT;
            cnt      <= '0;
            per_cur  <= '0;
            bip      <= 1'b0;
            motor_en <= 1'b1;
        end else begin
            motor_en <= zone_sil || (zone_idx != '0);
            if (zone_sil) begin
                state <= SILENT;
                cnt   <= '0;
                bip   <= 1'b0;
            end else if (zone_idx == '0) begin
                state <= CONT;
                cnt   <= '0;
                bip   <= 1'b1;
            end else begin
                case (state)
                    SILENT, CONT: begin
                        per_cur <= per_new;
                        cnt     <= '0;
                        if (per_new[CW-1:1] == '0) begin
                            state <= HIGH;
                            bip   <= 1'b1;
                        end else begin
                            state <= LOW;
                            bip   <= 1'b0;
                        end
                    end
                    LOW: begin
                        cnt <= cnt + CW'(1);
                        if (cnt == (per_cur >> 1) - CW'(1)) begin
                            state <= HIGH;
                            bip   <= 1'b1;
                        end
                    end
                    HIGH: begin
                        if (cnt == per_cur - CW'(1)) begin
                            per_cur <= per_new;
                            cnt     <= '0;
                            if (per_new[CW-1:1] == '0) begin
                                state <= HIGH;
                                bip   <= 1'b1;
                            end else begin
                                state <= LOW;
                                bip   <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bip_en = bip & ~mute;
    assign zone   = {zone_sil, zone_idx};

endmodule

// File: doc/bip_zone_gen.md
Name: bip_zone_gen

Overview:
Parametrised successor of the single-channel proximity beeper. It takes N distance channels and tracks the nearest valid one. A runtime-programmable zone table maps that distance to a beep period, with hysteresis on retreat. The block drives bip_en, motor_en and a status zone, and sits between the distance converters and the buzzer/motor drivers.

Parameters:
N_CH, 4, number of distance channels (1..8)
DW, 12, distance width per channel (cm)
NZ, 8, zone table entries (power of 2, >=2)
CW, 26, period counter width (clock cycles)
HYST, 5, retreat hysteresis in distance units
STALE_CYC, 50000000, cycles without a sample before a channel is invalidated

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
dst  in  N_CH*DW  channel i distance at [i*DW +: DW]
dst_valid  in  N_CH  per-channel one-cycle sample strobe
mute  in  1  forces bip_en low; motor_en unaffected
cfg_we  in  1  zone table write strobe
cfg_addr  in  log2(NZ)  table index
cfg_thr  in  DW  zone threshold, upper inclusive bound
cfg_period  in  CW  beep period in cycles; 0 = entry disabled
bip_en  out  1  beeper enable
motor_en  out  1  0 = stop motor (inside zone 0)
zone  out  log2(NZ)+1  MSB = silent flag; LSBs = current zone index
near_ch  out  log2(N_CH) (min 1)  index of nearest valid channel

Behaviour:
- Reset (rst high at a clk edge) clears all of the following, regardless of what is in progress:
  - channel regs and valid flags
  - stale counters
  - zone table: thr=0, period=0
  - period counter
- Output reset values: bip_en=0, motor_en=1, zone={1,0..0} (silent), near_ch=0.
- Channel stage:
  - dst_valid[i] high at edge t latches dst[i], sets valid[i] and zeroes stale_cnt[i] at t+1.
  - Otherwise stale_cnt[i] increments. When it reaches STALE_CYC-1, valid[i] clears and the counter saturates.
- Min stage (registered, t+2):
  - min_dst and near_ch are taken over valid channels only.
  - Ties go to the lowest index.
  - No valid channel: no_tgt=1 and near_ch holds its last value.
- Zone stage (registered, t+3):
  - Entry k is enabled when period[k]!=0. Entry 0 is the exception: it is enabled when thr[0]!=0 and its period is ignored.
  - Candidate = lowest enabled k with min_dst <= thr[k]. If there is none, or no_tgt, the candidate is silent.
  - Candidate nearer than the current zone (lower index, or any zone vs silent): adopt immediately.
  - Candidate farther: adopt only when min_dst > thr[cur]+HYST. Compute in DW+1 bits, no wrap. Otherwise hold the current zone.
  - no_tgt forces silent immediately, bypassing hysteresis.
- Table writes take effect the next cycle and are seen by the following zone evaluation. A write and a lookup in the same cycle use the old value.
- Output stage, FSM states SILENT, CONT, LOW, HIGH:
  - SILENT: bip_en=0, counter=0. Zone 0 -> CONT; zone k>0 -> LOW with P=period[k] latched.
  - CONT (zone 0): bip_en=1, motor_en=0. Leaves to SILENT or LOW on a zone change.
  - LOW: bip_en=0, counter increments. At counter = P/2 - 1 -> HIGH.
  - HIGH: bip_en=1. At counter = P-1 -> counter=0, reload P from the current zone, -> LOW. A new P therefore applies only at the period boundary (glitch-free).
  - A change to silent or to zone 0 acts immediately from any state.
  - P=1 behaves as P/2=0: HIGH for 1 cycle, then LOW for 0 cycles, i.e. bip_en steady 1.
- Output gating:
  - motor_en = 0 iff current zone == 0.
  - bip_en output = FSM bip & ~mute. mute does not stop the counter, so unmuting stays phase-aligned.
- Latency from dst_valid to bip_en/motor_en response is 4 cycles. zone is valid at t+3.

Test Plan:
1. Reset, write zone table entry 0 thr=50, entry 1 thr=70 P=10, entry 2 thr=100 P=20 (entry 3 left disabled); drive ch0=80 -> zone=2 at t+3; bip_en repeats 10 low / 10 high; motor_en=1.
2. ch0=60 while ch1=40 -> near_ch=1, zone=0, bip_en steady 1, motor_en=0 from t+4.
3. Hysteresis: from zone 1 (dst 70), dst=73 -> stays zone 1; dst=76 (>70+5) -> zone 2. Period change lands only at a HIGH->LOW boundary, with no short pulse.
4. Stale: STALE_CYC=100, one sample of ch2=30 then none -> valid[2] clears after 100 cycles; zone silent, bip_en=0 immediately.
5. mute=1 in zone 2 -> bip_en=0 while the counter runs; mute=0 mid-period -> bip_en resumes at the correct phase.
6. rst asserted in HIGH state -> next cycle bip_en=0, motor_en=1, zone=silent, table cleared; a sample with an empty table -> stays silent.
